// File: rtl/vliw_pkg.sv
// Shared opcode constants, writeback-tag type and instruction field slicers for the VLIW issue stage.
package vliw_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned RIDX_W  = 6;
  localparam int unsigned RD_W    = 7;
  localparam int unsigned IMM_W   = 14;
  localparam int unsigned DADDR_W = 30;

  localparam logic [2:0] OP_IMM   = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  // Shares its encoding with OP_LOAD; an ALU lane treats it as upper-immediate.
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] FUNCT_LUI = 3'b010;

  typedef struct packed {
    logic              we;
    logic [RIDX_W-1:0] idx;
  } rd_t;

  function automatic logic [2:0] f_op(input logic [INST_W-1:0] inst);
    return inst[2:0];
  endfunction

  function automatic logic [2:0] f_funct(input logic [INST_W-1:0] inst);
    return inst[5:3];
  endfunction

  function automatic logic [RIDX_W-1:0] f_rs1(input logic [INST_W-1:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [RIDX_W-1:0] f_rs2(input logic [INST_W-1:0] inst);
    return inst[11:6];
  endfunction

  function automatic logic [RIDX_W-1:0] f_rd(input logic [INST_W-1:0] inst);
    return inst[25:20];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm_i(input logic [INST_W-1:0] inst);
    return inst[19:6];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm_s(input logic [INST_W-1:0] inst);
    return inst[25:12];
  endfunction

  function automatic logic [INST_W-1:0] f_upper(input logic [INST_W-1:0] inst);
    return {inst[31:26], inst[19:6], 12'b0};
  endfunction

endpackage

// File: rtl/vliw_bypass_mux.sv
// Operand resolver for one source register: zero reg, EX ALU forward, EX load hazard,
// writeback forward, then register file. Highest lane/port index wins inside a stage.
module vliw_bypass_mux
  import vliw_pkg::*;
#(
  parameter int unsigned NLANE = 4,
  parameter int unsigned NALU  = 2,
  parameter int unsigned NWB   = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic [RIDX_W-1:0]     idx_i,
  input  logic [XLEN-1:0]       rf_data_i,
  input  logic [NLANE*RD_W-1:0] ex_rd_i,
  input  logic [NALU*XLEN-1:0]  ex_res_i,
  input  logic [NWB*RD_W-1:0]   wb_rd_i,
  input  logic [NWB*XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  hazard_o
);

  logic            ex_hit, ld_hit, wb_hit;
  logic [XLEN-1:0] ex_data, wb_sel;

  always_comb begin
    ex_hit  = 1'b0;
    ex_data = '0;
    ld_hit  = 1'b0;
    wb_hit  = 1'b0;
    wb_sel  = '0;
    for (int i = 0; i < NALU; i++) begin
      if (ex_rd_i[i*RD_W+RIDX_W] && (ex_rd_i[i*RD_W +: RIDX_W] == idx_i)) begin
        ex_hit  = 1'b1;
        ex_data = ex_res_i[i*XLEN +: XLEN];
      end
    end
    for (int i = NALU; i < NLANE; i++) begin
      if (ex_rd_i[i*RD_W+RIDX_W] && (ex_rd_i[i*RD_W +: RIDX_W] == idx_i)) begin
        ld_hit = 1'b1;
      end
    end
    for (int i = 0; i < NWB; i++) begin
      if (wb_rd_i[i*RD_W+RIDX_W] && (wb_rd_i[i*RD_W +: RIDX_W] == idx_i)) begin
        wb_hit = 1'b1;
        wb_sel = wb_data_i[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    if (idx_i == '0) begin
      data_o = '0;
    end else if (ex_hit) begin
      data_o = ex_data;
    end else if (ld_hit) begin
      hazard_o = 1'b1;
    end else if (wb_hit) begin
      data_o = wb_sel;
    end
  end

endmodule

// File: rtl/vliw_issue.sv
// VLIW decode/operand-fetch stage with bypassing, load-use bubbles and a fetch handshake.
// Optional perf counters (issued, hazard bubbles, hold cycles) under `ISSUE_PERF_EN.
module vliw_issue
  import vliw_pkg::*;
#(
  parameter int unsigned NLANE = 4,
  parameter int unsigned NALU  = 2,
  parameter int unsigned NWB   = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NLANE*32-1:0]         in_inst,
  output logic                        in_ready,
  output logic [2*NLANE*6-1:0]        rf_raddr,
  input  logic [2*NLANE*XLEN-1:0]     rf_rdata,
  input  logic [NLANE*7-1:0]          ex_rd,
  input  logic [NALU*XLEN-1:0]        ex_res,
  input  logic [NWB*7-1:0]            wb_rd,
  input  logic [NWB*XLEN-1:0]         wb_data,
  input  logic                        stall,
  input  logic                        flush,
  output logic                        iss_valid,
  output logic [NLANE*XLEN-1:0]       iss_op1,
  output logic [NLANE*XLEN-1:0]       iss_op2,
  output logic [NLANE*6-1:0]          iss_ctl,
  output logic [NLANE*7-1:0]          iss_rd,
  output logic [(NLANE-NALU)*30-1:0]  iss_daddr,
  output logic [NLANE-NALU-1:0]       iss_mre,
  output logic [NLANE-NALU-1:0]       iss_mwe,
  output logic                        hazard
`ifdef ISSUE_PERF_EN
  ,
  output logic [31:0]                 perf_issued,
  output logic [31:0]                 perf_hazard,
  output logic [31:0]                 perf_hold
`endif
);

  localparam int unsigned NMEM = NLANE - NALU;

  logic [XLEN-1:0]    lane_op1 [NLANE];
  logic [XLEN-1:0]    lane_op2 [NLANE];
  logic [5:0]         lane_ctl [NLANE];
  rd_t                lane_rd  [NLANE];
  logic [DADDR_W-1:0] mem_daddr [NMEM];
  logic [NMEM-1:0]    mem_mre, mem_mwe;
  logic [2*NLANE-1:0] src_haz;
  logic               accept;

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    logic [INST_W-1:0] inst;
    logic [2:0]        op;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm_i;
    logic [IMM_W-1:0]  imm_i_raw;
    logic              lane_we;

    assign inst      = in_inst[(NLANE-1-l)*INST_W +: INST_W];
    assign op        = f_op(inst);
    assign imm_i_raw = f_imm_i(inst);
    assign imm_i     = {{(XLEN-IMM_W){imm_i_raw[IMM_W-1]}}, imm_i_raw};
    assign rf_raddr[l*2*RIDX_W +: 2*RIDX_W] = {f_rs1(inst), f_rs2(inst)};

    vliw_bypass_mux #(.NLANE(NLANE), .NALU(NALU), .NWB(NWB), .XLEN(XLEN)) u_rs1 (
      .idx_i     (f_rs1(inst)),
      .rf_data_i (rf_rdata[(2*l+1)*XLEN +: XLEN]),
      .ex_rd_i   (ex_rd),
      .ex_res_i  (ex_res),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .data_o    (rs1_data),
      .hazard_o  (src_haz[2*l+1])
    );

    vliw_bypass_mux #(.NLANE(NLANE), .NALU(NALU), .NWB(NWB), .XLEN(XLEN)) u_rs2 (
      .idx_i     (f_rs2(inst)),
      .rf_data_i (rf_rdata[2*l*XLEN +: XLEN]),
      .ex_rd_i   (ex_rd),
      .ex_res_i  (ex_res),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .data_o    (rs2_data),
      .hazard_o  (src_haz[2*l])
    );

    assign lane_op1[l] = rs1_data;
    assign lane_op2[l] = (op == OP_IMM) ? imm_i :
                         (op == OP_LUI) ? XLEN'(f_upper(inst)) : rs2_data;
    assign lane_ctl[l] = {op, f_funct(inst)};
    assign lane_rd[l]  = {lane_we, f_rd(inst)};

    if (l >= NALU) begin : g_mem
      localparam int unsigned M = l - NALU;
      logic [IMM_W-1:0]   imm_s_raw;
      logic [DADDR_W-1:0] offset;

      assign imm_s_raw    = f_imm_s(inst);
      assign offset       = (op == OP_LOAD) ? imm_i[DADDR_W-1:0] :
                            {{(DADDR_W-IMM_W){imm_s_raw[IMM_W-1]}}, imm_s_raw};
      assign mem_daddr[M] = rs1_data[DADDR_W-1:0] + offset;
      assign mem_mre[M]   = (op == OP_LOAD);
      assign mem_mwe[M]   = (op == OP_STORE);
      assign lane_we      = mem_mre[M];
    end else begin : g_alu
      assign lane_we = ~op[2] | (op == OP_IMM) | ({f_funct(inst), op} == {FUNCT_LUI, OP_LUI});
    end
  end

  assign hazard   = in_valid & (|src_haz);
  assign accept   = in_valid & ~rst & ~flush & ~stall & ~hazard;
  assign in_ready = accept;

  logic                       valid_q, valid_d;
  logic [NLANE*XLEN-1:0]      op1_q, op1_d, op2_q, op2_d;
  logic [NLANE*6-1:0]         ctl_q, ctl_d;
  logic [NLANE*RD_W-1:0]      rd_q, rd_d;
  logic [NMEM*DADDR_W-1:0]    daddr_q, daddr_d;
  logic [NMEM-1:0]            mre_q, mre_d, mwe_q, mwe_d;

  always_comb begin
    valid_d = 1'b0;
    op1_d   = '0;
    op2_d   = '0;
    ctl_d   = '0;
    rd_d    = '0;
    daddr_d = '0;
    mre_d   = '0;
    mwe_d   = '0;
    // Anything not held or accepted (reset, flush, hazard, no input) issues an all-zero bubble.
    if (!(rst || flush)) begin
      if (stall) begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        ctl_d   = ctl_q;
        rd_d    = rd_q;
        daddr_d = daddr_q;
        mre_d   = mre_q;
        mwe_d   = mwe_q;
      end else if (accept) begin
        valid_d = 1'b1;
        for (int l = 0; l < NLANE; l++) begin
          op1_d[l*XLEN +: XLEN] = lane_op1[l];
          op2_d[l*XLEN +: XLEN] = lane_op2[l];
          ctl_d[l*6 +: 6]       = lane_ctl[l];
          rd_d[l*RD_W +: RD_W]  = lane_rd[l];
        end
        for (int j = 0; j < NMEM; j++) begin
          daddr_d[j*DADDR_W +: DADDR_W] = mem_daddr[j];
        end
        mre_d = mem_mre;
        mwe_d = mem_mwe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      ctl_q   <= '0;
      rd_q    <= '0;
      daddr_q <= '0;
      mre_q   <= '0;
      mwe_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
      daddr_q <= daddr_d;
      mre_q   <= mre_d;
      mwe_q   <= mwe_d;
    end
  end

  assign iss_valid = valid_q;
  assign iss_op1   = op1_q;
  assign iss_op2   = op2_q;
  assign iss_ctl   = ctl_q;
  assign iss_rd    = rd_q;
  assign iss_daddr = daddr_q;
  assign iss_mre   = mre_q;
  assign iss_mwe   = mwe_q;

`ifdef ISSUE_PERF_EN
  // RUN/HOLD tracking feeds only the hold-cycle counter.
  typedef enum logic [0:0] {StRun, StHold} state_e;
  state_e      state_q, state_d;
  logic [31:0] issued_q, issued_d, haz_q, haz_d, hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (in_valid && (stall || hazard)) state_d = StHold;
      StHold:  if (accept) state_d = StRun;
      default: state_d = StRun;
    endcase
    if (flush) state_d = StRun;

    issued_d = issued_q;
    haz_d    = haz_q;
    hold_d   = hold_q;
    if (accept && !(&issued_q)) issued_d = issued_q + 32'd1;
    if (hazard && !flush && !stall && !(&haz_q)) haz_d = haz_q + 32'd1;
    if ((state_q == StHold) && !(&hold_q)) hold_d = hold_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      issued_q <= '0;
      haz_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      haz_q    <= haz_d;
      hold_q   <= hold_d;
    end
  end

  assign perf_issued = issued_q;
  assign perf_hazard = haz_q;
  assign perf_hold   = hold_q;
`endif

endmodule
